ysyx_22050710_dsram_axi_bridge: RTL and testbench

Responder end of the data-SRAM-like interface driven by the execute stage: it accepts req/addr_ok requests and returns data_ok/rdata.
It converts each request into one AXI4-lite style master transaction (AR/R for reads, AW/W/B for writes).
It sits between the core's data port and the memory/crossbar.
Only one transaction is outstanding at a time.

---
 rtl/ysyx_22050710_dsram_axi_bridge_pkg.sv | 25 ++
 rtl/ysyx_22050710_dsram_axi_bridge.sv | 192 +++++++++++++++++++
 tb/tb_ysyx_22050710_dsram_axi_bridge.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050710_dsram_axi_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050710_dsram_axi_bridge_pkg
// Brief    : Shared FSM encodings, AXI response codes and size mapping helper
// Revision : 1.0
// ============================================================================
package ysyx_22050710_dsram_axi_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      WR_REQ  = 3'd3,
      WR_RESP = 3'd4
   } state_e;

   localparam logic [1:0] c_resp_okay   = 2'b00;
   localparam logic [1:0] c_resp_slverr = 2'b10;

   function automatic logic [2:0] size_to_axsize(input logic [1:0] size);
      return {1'b0, size};
   endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22050710_dsram_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050710_dsram_axi_bridge
// Brief    : SRAM-like data port to single-outstanding AXI4-lite master bridge.
//            Optional response error output: YSYX_22050710_DBRIDGE_RESP_ERR_EN
// Revision : 1.0
// ============================================================================
module ysyx_22050710_dsram_axi_bridge #(
   parameter int SRAM_ADDR_WD  = 32,
   parameter int SRAM_DATA_WD  = 64,
   parameter int SRAM_WMASK_WD = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_req,
   input  logic                     i_wr,
   input  logic [1:0]               i_size,
   input  logic [SRAM_ADDR_WD-1:0]  i_addr,
   input  logic [SRAM_WMASK_WD-1:0] i_wstrb,
   input  logic [SRAM_DATA_WD-1:0]  i_wdata,
   output logic                     o_addr_ok,
   output logic                     o_data_ok,
   output logic [SRAM_DATA_WD-1:0]  o_rdata,
`ifdef YSYX_22050710_DBRIDGE_RESP_ERR_EN
   output logic                     o_data_err,
`endif
   output logic                     o_arvalid,
   input  logic                     i_arready,
   output logic [SRAM_ADDR_WD-1:0]  o_araddr,
   output logic [2:0]               o_arsize,
   input  logic                     i_rvalid,
   output logic                     o_rready,
   input  logic [SRAM_DATA_WD-1:0]  i_rdata,
   input  logic [1:0]               i_rresp,
   output logic                     o_awvalid,
   input  logic                     i_awready,
   output logic [SRAM_ADDR_WD-1:0]  o_awaddr,
   output logic [2:0]               o_awsize,
   output logic                     o_wvalid,
   input  logic                     i_wready,
   output logic [SRAM_DATA_WD-1:0]  o_wdata,
   output logic [SRAM_WMASK_WD-1:0] o_wstrb,
   input  logic                     i_bvalid,
   output logic                     o_bready,
   input  logic [1:0]               i_bresp
);
   import ysyx_22050710_dsram_axi_bridge_pkg::*;

   state_e                   r_state;
   state_e                   w_state_next;
   logic [1:0]               r_size;
   logic [SRAM_ADDR_WD-1:0]  r_addr;
   logic [SRAM_DATA_WD-1:0]  r_wdata;
   logic [SRAM_WMASK_WD-1:0] r_wstrb;
   logic                     r_aw_done;
   logic                     r_w_done;
   logic                     r_data_ok;
   logic [SRAM_DATA_WD-1:0]  r_rdata;

   logic w_aw_hs;
   logic w_w_hs;
   logic w_r_hs;
   logic w_b_hs;

   assign o_addr_ok = (r_state == IDLE) & i_req;

   // Every AXI-facing value comes from the latched request, never from i_*.
   assign o_arvalid = (r_state == RD_ADDR);
   assign o_rready  = (r_state == RD_DATA);
   assign o_awvalid = (r_state == WR_REQ) & ~r_aw_done;
   assign o_wvalid  = (r_state == WR_REQ) & ~r_w_done;
   assign o_bready  = (r_state == WR_RESP);
   assign o_araddr  = r_addr;
   assign o_awaddr  = r_addr;
   assign o_arsize  = size_to_axsize(r_size);
   assign o_awsize  = size_to_axsize(r_size);
   assign o_wdata   = r_wdata;
   assign o_wstrb   = r_wstrb;
   assign o_data_ok = r_data_ok;
   assign o_rdata   = r_rdata;

   assign w_aw_hs = o_awvalid & i_awready;
   assign w_w_hs  = o_wvalid  & i_wready;
   assign w_r_hs  = o_rready  & i_rvalid;
   assign w_b_hs  = o_bready  & i_bvalid;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (i_req) begin
               w_state_next = i_wr ? WR_REQ : RD_ADDR;
            end
         end
         RD_ADDR: begin
            if (i_arready) begin
               w_state_next = RD_DATA;
            end
         end
         RD_DATA: begin
            if (i_rvalid) begin
               w_state_next = IDLE;
            end
         end
         WR_REQ: begin
            if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
               w_state_next = WR_RESP;
            end
         end
         WR_RESP: begin
            if (i_bvalid) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_size  <= 2'd0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wstrb <= '0;
      end else if (o_addr_ok) begin
         r_size  <= i_size;
         r_addr  <= i_addr;
         r_wdata <= i_wdata;
         r_wstrb <= i_wstrb;
      end
   end

   // Sent flags only live inside WR_REQ; they clear as soon as the phase ends.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else if ((r_state != WR_REQ) || (w_state_next != WR_REQ)) begin
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else begin
         if (w_aw_hs) begin
            r_aw_done <= 1'b1;
         end
         if (w_w_hs) begin
            r_w_done <= 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_data_ok <= 1'b0;
         r_rdata   <= '0;
      end else begin
         r_data_ok <= w_r_hs | w_b_hs;
         if (w_r_hs) begin
            r_rdata <= i_rdata;
         end
      end
   end

`ifdef YSYX_22050710_DBRIDGE_RESP_ERR_EN
   logic r_data_err;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_data_err <= 1'b0;
      end else begin
         r_data_err <= (w_r_hs & (i_rresp != c_resp_okay)) |
                       (w_b_hs & (i_bresp != c_resp_okay));
      end
   end

   assign o_data_err = r_data_err;
`else
   logic w_unused_resp;
   assign w_unused_resp = ^{i_rresp, i_bresp};
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050710_dsram_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22050710_dsram_axi_bridge
// Brief    : Self-checking bench: vector table, corner sequences, random traffic
// Revision : 1.0
// ============================================================================
module tb_ysyx_22050710_dsram_axi_bridge;
   import ysyx_22050710_dsram_axi_bridge_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_req = 1'b0, i_wr = 1'b0;
   logic [1:0]  i_size = 2'd0;
   logic [31:0] i_addr = '0;
   logic [7:0]  i_wstrb = '0;
   logic [63:0] i_wdata = '0;
   logic        o_addr_ok, o_data_ok;
   logic [63:0] o_rdata;
   logic        o_arvalid, i_arready = 1'b0;
   logic [31:0] o_araddr;
   logic [2:0]  o_arsize;
   logic        i_rvalid = 1'b0, o_rready;
   logic [63:0] i_rdata = '0;
   logic [1:0]  i_rresp = 2'b00;
   logic        o_awvalid, i_awready = 1'b0;
   logic [31:0] o_awaddr;
   logic [2:0]  o_awsize;
   logic        o_wvalid, i_wready = 1'b0;
   logic [63:0] o_wdata;
   logic [7:0]  o_wstrb;
   logic        i_bvalid = 1'b0, o_bready;
   logic [1:0]  i_bresp = 2'b00;
`ifdef YSYX_22050710_DBRIDGE_RESP_ERR_EN
   logic        o_data_err;
`endif

   always #5 clk = ~clk;

   ysyx_22050710_dsram_axi_bridge #(
      .SRAM_ADDR_WD(32), .SRAM_DATA_WD(64), .SRAM_WMASK_WD(8)
   ) dut (
      .i_clk(clk), .i_rst(rst_n),
      .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr),
      .i_wstrb(i_wstrb), .i_wdata(i_wdata),
      .o_addr_ok(o_addr_ok), .o_data_ok(o_data_ok), .o_rdata(o_rdata),
`ifdef YSYX_22050710_DBRIDGE_RESP_ERR_EN
      .o_data_err(o_data_err),
`endif
      .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr), .o_arsize(o_arsize),
      .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rdata(i_rdata), .i_rresp(i_rresp),
      .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr), .o_awsize(o_awsize),
      .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata), .o_wstrb(o_wstrb),
      .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic [63:0] last_rdata = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic slave(input logic ar, input logic rv, input logic aw, input logic w, input logic b);
      i_arready = ar; i_rvalid = rv; i_awready = aw; i_wready = w; i_bvalid = b;
   endtask

   task automatic present(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                          input logic [63:0] wdata, input logic [7:0] wstrb);
      i_req = 1'b1; i_wr = wr; i_size = size; i_addr = addr; i_wdata = wdata; i_wstrb = wstrb;
   endtask

   task automatic wait_data_ok(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         step();
         #1;
         if (o_data_ok) seen = 1'b1;
      end
      check(name, seen, 1'b1);
   endtask

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic [7:0]  wstrb;
      logic [63:0] rdata;
      logic [2:0]  exp_axsize;
      logic [63:0] exp_rdata;
   } vec_t;

   vec_t vecs[5];

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b0, 2'd3, 32'h8000_0010, 64'h0, 8'h00, 64'h1122_3344_5566_7788, 3'd3, 64'h1122_3344_5566_7788};
      vecs[1] = '{1'b1, 2'd0, 32'h8000_0041, 64'h0000_0000_0000_AB00, 8'h02, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 64'h1122_3344_5566_7788};
      vecs[2] = '{1'b0, 2'd1, 32'h0000_1002, 64'h0, 8'h00, 64'h0000_0000_0000_BEEF, 3'd1, 64'h0000_0000_0000_BEEF};
      vecs[3] = '{1'b1, 2'd3, 32'h8000_0008, 64'hCAFE_BABE_0BAD_F00D, 8'hFF, 64'h5555_5555_5555_5555, 3'd3, 64'h0000_0000_0000_BEEF};
      vecs[4] = '{1'b0, 2'd2, 32'h8000_000C, 64'h0, 8'h00, 64'hA5A5_5A5A_0F0F_F0F0, 3'd2, 64'hA5A5_5A5A_0F0F_F0F0};

      // ---------------- reset state ----------------
      #12;
      check("rst_arvalid", o_arvalid, 1'b0);
      check("rst_awvalid", o_awvalid, 1'b0);
      check("rst_wvalid",  o_wvalid,  1'b0);
      check("rst_rready",  o_rready,  1'b0);
      check("rst_bready",  o_bready,  1'b0);
      check("rst_data_ok", o_data_ok, 1'b0);
      check("rst_rdata",   o_rdata,   64'h0);
      check("rst_araddr",  o_araddr,  32'h0);
      rst_n = 1'b1;
      step();

      // ---------------- table: all readies high, minimum latency ----------------
      foreach (vecs[k]) begin
         slave(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
         i_rdata = vecs[k].rdata;
         present(vecs[k].wr, vecs[k].size, vecs[k].addr, vecs[k].wdata, vecs[k].wstrb);
         #1;
         check($sformatf("v%0d_addr_ok", k), o_addr_ok, 1'b1);
         step();
         i_req = 1'b0;
         #1;
         if (vecs[k].wr) begin
            check($sformatf("v%0d_awvalid", k), o_awvalid, 1'b1);
            check($sformatf("v%0d_wvalid", k), o_wvalid, 1'b1);
            check($sformatf("v%0d_arvalid", k), o_arvalid, 1'b0);
            check($sformatf("v%0d_awaddr", k), o_awaddr, vecs[k].addr);
            check($sformatf("v%0d_awsize", k), o_awsize, vecs[k].exp_axsize);
            check($sformatf("v%0d_wdata", k), o_wdata, vecs[k].wdata);
            check($sformatf("v%0d_wstrb", k), o_wstrb, vecs[k].wstrb);
         end else begin
            check($sformatf("v%0d_arvalid", k), o_arvalid, 1'b1);
            check($sformatf("v%0d_awvalid", k), o_awvalid, 1'b0);
            check($sformatf("v%0d_araddr", k), o_araddr, vecs[k].addr);
            check($sformatf("v%0d_arsize", k), o_arsize, vecs[k].exp_axsize);
         end
         check($sformatf("v%0d_ok_t1", k), o_data_ok, 1'b0);
         step();
         #1;
         check($sformatf("v%0d_rsp_ready", k), vecs[k].wr ? o_bready : o_rready, 1'b1);
         check($sformatf("v%0d_ok_t2", k), o_data_ok, 1'b0);
         step();
         #1;
         check($sformatf("v%0d_ok_t3", k), o_data_ok, 1'b1);
         check($sformatf("v%0d_rdata", k), o_rdata, vecs[k].exp_rdata);
`ifdef YSYX_22050710_DBRIDGE_RESP_ERR_EN
         check($sformatf("v%0d_err", k), o_data_err, 1'b0);
`endif
         step();
         #1;
         check($sformatf("v%0d_ok_t4", k), o_data_ok, 1'b0);
         last_rdata = vecs[k].exp_rdata;
      end

      // ---------------- write with awready delayed, wready immediate ----------------
      slave(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      i_bresp = c_resp_slverr;
      present(1'b1, 2'd2, 32'h8000_0020, 64'h0000_0000_DEAD_BEEF, 8'h0F);
      #1;
      check("wr_addr_ok", o_addr_ok, 1'b1);
      step(); i_req = 1'b0; #1;
      check("wr_t1_awvalid", o_awvalid, 1'b1);
      check("wr_t1_wvalid",  o_wvalid,  1'b1);
      check("wr_t1_wdata",   o_wdata,   64'h0000_0000_DEAD_BEEF);
      check("wr_t1_awaddr",  o_awaddr,  32'h8000_0020);
      step(); #1;
      check("wr_t2_wvalid",  o_wvalid,  1'b0);
      check("wr_t2_awvalid", o_awvalid, 1'b1);
      check("wr_t2_bready",  o_bready,  1'b0);
      step(); i_awready = 1'b1; #1;
      check("wr_t3_awvalid", o_awvalid, 1'b1);
      step(); i_awready = 1'b0; #1;
      check("wr_t4_awvalid", o_awvalid, 1'b0);
      check("wr_t4_bready",  o_bready,  1'b1);
      step(); i_bvalid = 1'b1; #1;
      check("wr_t5_bready",  o_bready,  1'b1);
      check("wr_t5_ok",      o_data_ok, 1'b0);
      step(); i_bvalid = 1'b0; #1;
      check("wr_ok",         o_data_ok, 1'b1);
      check("wr_rdata_keep", o_rdata,   last_rdata);
`ifdef YSYX_22050710_DBRIDGE_RESP_ERR_EN
      check("wr_err_slverr", o_data_err, 1'b1);
`endif
      i_bresp = c_resp_okay;
      step(); #1;
      check("wr_ok_pulse", o_data_ok, 1'b0);

      // ---------------- busy rejection, back-to-back acceptance ----------------
      slave(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      i_rdata = 64'h0102_0304_0506_0708;
      present(1'b0, 2'd3, 32'h8000_0200, 64'h0, 8'h00);
      #1;
      check("busy_first_ok", o_addr_ok, 1'b1);
      step();
      present(1'b0, 2'd2, 32'h8000_0300, 64'h0, 8'h00);
      #1;
      check("busy_t1_addr_ok", o_addr_ok, 1'b0);
      step(); #1;
      check("busy_t2_addr_ok", o_addr_ok, 1'b0);
      step(); #1;
      check("busy_t3_data_ok", o_data_ok, 1'b1);
      check("busy_t3_addr_ok", o_addr_ok, 1'b1);
      check("busy_first_rdata", o_rdata, 64'h0102_0304_0506_0708);
      i_rdata = 64'h1111_2222_3333_4444;
      step(); i_req = 1'b0; #1;
      check("busy_second_araddr", o_araddr, 32'h8000_0300);
      wait_data_ok("busy_second_done");
      check("busy_second_rdata", o_rdata, 64'h1111_2222_3333_4444);

      // ---------------- AR stall hold ----------------
      slave(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      present(1'b0, 2'd1, 32'h8000_0106, 64'h0, 8'h00);
      step(); i_req = 1'b0;
      i_addr = 32'hFFFF_FFFF; i_size = 2'd0;
      for (int c = 0; c < 5; c++) begin
         #1;
         check($sformatf("stall%0d_arvalid", c), o_arvalid, 1'b1);
         check($sformatf("stall%0d_araddr", c), o_araddr, 32'h8000_0106);
         check($sformatf("stall%0d_arsize", c), o_arsize, 3'd1);
         step();
      end
      i_arready = 1'b1;
      i_rdata = 64'h7766_5544_3322_1100;
      wait_data_ok("stall_done");
      check("stall_rdata", o_rdata, 64'h7766_5544_3322_1100);

      // ---------------- reset in the middle of a read ----------------
      slave(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      present(1'b0, 2'd3, 32'h8000_0400, 64'h0, 8'h00);
      step(); i_req = 1'b0;
      step(); #1;
      check("mid_rready", o_rready, 1'b1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_rready", o_rready, 1'b0);
      check("mid_rst_arvalid", o_arvalid, 1'b0);
      check("mid_rst_data_ok", o_data_ok, 1'b0);
      check("mid_rst_rdata", o_rdata, 64'h0);
      i_rvalid = 1'b1;
      i_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
      step(); step();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step(); #1;
         check($sformatf("mid_post%0d_data_ok", c), o_data_ok, 1'b0);
         check($sformatf("mid_post%0d_rready", c), o_rready, 1'b0);
      end
      i_rdata = 64'h0BAD_CAFE_0000_0001;
      present(1'b0, 2'd3, 32'h8000_0500, 64'h0, 8'h00);
      #1;
      check("mid_next_addr_ok", o_addr_ok, 1'b1);
      step(); i_req = 1'b0;
      wait_data_ok("mid_next_done");
      check("mid_next_rdata", o_rdata, 64'h0BAD_CAFE_0000_0001);
      last_rdata = 64'h0BAD_CAFE_0000_0001;

      // ---------------- random traffic vs transaction-level model ----------------
      for (int t = 0; t < 60; t++) begin
         logic        wr;
         logic [1:0]  size;
         logic [31:0] addr;
         logic [63:0] wdata;
         logic [7:0]  wstrb;
         int n_ar, n_r, n_aw, n_w, n_b;
         bit exp_ok, done, prev_ar_wait, prev_aw_wait, prev_w_wait;
         logic exp_err;
         wr = 1'($urandom_range(0, 1));
         size = 2'($urandom_range(0, 3));
         addr = $urandom;
         wdata = {$urandom, $urandom};
         wstrb = 8'($urandom);
         n_ar = 0; n_r = 0; n_aw = 0; n_w = 0; n_b = 0;
         exp_ok = 1'b0; done = 1'b0; exp_err = 1'b0;
         prev_ar_wait = 1'b0; prev_aw_wait = 1'b0; prev_w_wait = 1'b0;
         slave(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         present(wr, size, addr, wdata, wstrb);
         #1;
         check("rnd_addr_ok", o_addr_ok, 1'b1);
         step();
         i_req = 1'b0;
         for (int c = 0; c < 200 && !done; c++) begin
            slave(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            i_rdata = {$urandom, $urandom};
            i_rresp = 2'($urandom_range(0, 3));
            i_bresp = 2'($urandom_range(0, 3));
            i_addr = $urandom;
            #1;
            check("rnd_data_ok", o_data_ok, exp_ok);
            if (o_data_ok) begin
               done = 1'b1;
               check("rnd_rdata", o_rdata, last_rdata);
`ifdef YSYX_22050710_DBRIDGE_RESP_ERR_EN
               check("rnd_err", o_data_err, exp_err);
`endif
            end else begin
               if (prev_ar_wait) check("rnd_ar_hold", o_arvalid, 1'b1);
               if (prev_aw_wait) check("rnd_aw_hold", o_awvalid, 1'b1);
               if (prev_w_wait)  check("rnd_w_hold",  o_wvalid,  1'b1);
               if (o_arvalid) begin
                  check("rnd_araddr", o_araddr, addr);
                  check("rnd_arsize", o_arsize, {1'b0, size});
               end
               if (o_awvalid) begin
                  check("rnd_awaddr", o_awaddr, addr);
                  check("rnd_awsize", o_awsize, {1'b0, size});
               end
               if (o_wvalid) begin
                  check("rnd_wdata", o_wdata, wdata);
                  check("rnd_wstrb", o_wstrb, wstrb);
               end
               if (o_rready) check("rnd_r_after_ar", n_ar, 1);
               if (o_bready) check("rnd_b_after_aw_w", n_aw + n_w, 2);
               exp_ok = 1'b0;
               prev_ar_wait = o_arvalid & ~i_arready;
               prev_aw_wait = o_awvalid & ~i_awready;
               prev_w_wait  = o_wvalid & ~i_wready;
               if (o_arvalid & i_arready) n_ar++;
               if (o_awvalid & i_awready) n_aw++;
               if (o_wvalid & i_wready)   n_w++;
               if (o_rready & i_rvalid) begin
                  n_r++;
                  exp_ok = 1'b1;
                  exp_err = (i_rresp != c_resp_okay);
                  last_rdata = i_rdata;
               end
               if (o_bready & i_bvalid) begin
                  n_b++;
                  exp_ok = 1'b1;
                  exp_err = (i_bresp != c_resp_okay);
               end
               step();
            end
         end
         if (!done) check("rnd_timeout", 1'b0, 1'b1);
         if (wr) check("rnd_wr_beats", {n_ar, n_r, n_aw, n_w, n_b}, {32'd0, 32'd0, 32'd1, 32'd1, 32'd1});
         else    check("rnd_rd_beats", {n_ar, n_r, n_aw, n_w, n_b}, {32'd1, 32'd1, 32'd0, 32'd0, 32'd0});
         i_rresp = c_resp_okay;
         i_bresp = c_resp_okay;
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
